// File: rtl/fp_addsub_pipe.sv
// Parametrised floating-point add/subtract: IDLE -> ALIGN -> ADD -> NORM -> DONE, done 4 cycles after start.
// Define FP_ADDSUB_RNE_EN for round-to-nearest-even; otherwise the result is truncated toward zero.
module fp_addsub_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 start,
  input  logic                 sub,
  input  logic [EXP_W+MAN_W:0] op1,
  input  logic [EXP_W+MAN_W:0] op2,
  output logic                 busy,
  output logic [EXP_W+MAN_W:0] result,
  output logic                 done,
  output logic                 overflow
);

  localparam int unsigned W  = 1 + EXP_W + MAN_W;
  localparam int unsigned XW = MAN_W + 4;
  localparam int unsigned SW = XW + 1;
  localparam int unsigned LW = $clog2(XW);
  localparam int unsigned EW = EXP_W + LW + 2;
  localparam logic signed [EW-1:0] EXP_ONE = EW'(1);
  localparam logic signed [EW-1:0] EXP_MAX = EW'((2 ** EXP_W) - 1);

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_DONE} state_t;
  state_t state_q, state_d;

  logic [W-1:0]     op1_q, op2_q;
  logic             sub_q;
  logic             sign_a_q, eff_sub_q, zero_sign_q;
  logic [EXP_W-1:0] exp_a_q;
  logic [XW-1:0]    man_a_q, man_b_q;
  logic [SW-1:0]    sum_q;
  logic [W-1:0]     result_q;
  logic             overflow_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_ALIGN;
      S_ALIGN: state_d = S_ADD;
      S_ADD:   state_d = S_NORM;
      S_NORM:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      op1_q <= '0;
      op2_q <= '0;
      sub_q <= 1'b0;
    end else if (state_q == S_IDLE && start) begin
      op1_q <= op1;
      op2_q <= op2;
      sub_q <= sub;
    end
  end

  // Alignment: a zero exponent flushes the operand to magnitude zero before the swap compare.
  logic [EXP_W-1:0] e1, e2, ea, eb, diff;
  logic [W-2:0]     mag1, mag2;
  logic             swap, sa, sb;
  logic [MAN_W-1:0] fa, fb;
  logic [XW-1:0]    ext_a, ext_b, shifted, lost;

  always_comb begin
    e1   = op1_q[W-2 -: EXP_W];
    e2   = op2_q[W-2 -: EXP_W];
    mag1 = (e1 == '0) ? '0 : op1_q[W-2:0];
    mag2 = (e2 == '0) ? '0 : op2_q[W-2:0];
    swap = mag2 > mag1;
    if (swap) begin
      sa = op2_q[W-1] ^ sub_q;
      sb = op1_q[W-1];
      ea = e2;
      eb = e1;
      fa = op2_q[MAN_W-1:0];
      fb = op1_q[MAN_W-1:0];
    end else begin
      sa = op1_q[W-1];
      sb = op2_q[W-1] ^ sub_q;
      ea = e1;
      eb = e2;
      fa = op1_q[MAN_W-1:0];
      fb = op2_q[MAN_W-1:0];
    end
    ext_a = (ea == '0) ? '0 : {1'b1, fa, 3'b000};
    ext_b = (eb == '0) ? '0 : {1'b1, fb, 3'b000};
    diff  = ea - eb;
    {shifted, lost} = {ext_b, {XW{1'b0}}} >> diff;
    if (32'(diff) >= XW) begin
      shifted = '0;
      lost    = ext_b;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sign_a_q    <= 1'b0;
      eff_sub_q   <= 1'b0;
      zero_sign_q <= 1'b0;
      exp_a_q     <= '0;
      man_a_q     <= '0;
      man_b_q     <= '0;
    end else if (state_q == S_ALIGN) begin
      sign_a_q    <= sa;
      eff_sub_q   <= sa ^ sb;
      zero_sign_q <= sa & sb;
      exp_a_q     <= ea;
      man_a_q     <= ext_a;
      man_b_q     <= {shifted[XW-1:1], shifted[0] | (|lost)};
    end
  end

  // |A| >= |B| after the swap, so the subtraction never goes negative.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sum_q <= '0;
    end else if (state_q == S_ADD) begin
      sum_q <= eff_sub_q ? ({1'b0, man_a_q} - {1'b0, man_b_q})
                         : ({1'b0, man_a_q} + {1'b0, man_b_q});
    end
  end

  logic [LW-1:0]        lzc;
  logic                 found;
  logic [XW-1:3]        m_hi;
  logic [MAN_W-1:0]     frac_r;
  logic                 round_up, rc, ovf_n;
  logic signed [EW-1:0] e_n, e_r;
  logic [W-1:0]         res_n;
`ifdef FP_ADDSUB_RNE_EN
  logic [2:0]           grs;
`endif

  // m_hi is the normalised {hidden, frac}; its hidden bit is clear only for a zero sum.
  always_comb begin
    lzc   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < XW; i++) begin
      if (!found && sum_q[XW-1-i]) begin
        lzc   = LW'(i);
        found = 1'b1;
      end
    end
    if (sum_q[SW-1]) begin
      m_hi = sum_q[SW-1:4];
      e_n  = EW'(exp_a_q) + EXP_ONE;
`ifdef FP_ADDSUB_RNE_EN
      grs  = {sum_q[3], sum_q[2], sum_q[1] | sum_q[0]};
`endif
    end else begin
      m_hi = (XW-3)'((sum_q[XW-1:0] << lzc) >> 3);
      e_n  = EW'(exp_a_q) - EW'(lzc);
`ifdef FP_ADDSUB_RNE_EN
      grs  = 3'(sum_q[XW-1:0] << lzc);
`endif
    end
`ifdef FP_ADDSUB_RNE_EN
    round_up = grs[2] & (grs[1] | grs[0] | m_hi[3]);
`else
    round_up = 1'b0;
`endif
    {rc, frac_r} = {1'b0, m_hi[XW-2:3]} + (MAN_W+1)'(round_up);
    e_r   = e_n + EW'(rc);
    ovf_n = 1'b0;
    if (!m_hi[XW-1]) begin
      res_n = {zero_sign_q, {(W-1){1'b0}}};
    end else if (e_r >= EXP_MAX) begin
      res_n = {sign_a_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      ovf_n = 1'b1;
    end else if (e_r < EXP_ONE) begin
      res_n = {sign_a_q, {(W-1){1'b0}}};
    end else begin
      res_n = {sign_a_q, e_r[EXP_W-1:0], frac_r};
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else if (state_q == S_NORM) begin
      result_q   <= res_n;
      overflow_q <= ovf_n;
    end
  end

  assign busy     = (state_q == S_ALIGN) || (state_q == S_ADD) || (state_q == S_NORM);
  assign done     = (state_q == S_DONE);
  assign result   = result_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Bench for fp_addsub_pipe: directed vector table, random ops against an exact-arithmetic model,
// plus handshake, reset-abort and half-precision sequences.
module tb_fp_addsub_pipe;

`ifdef FP_ADDSUB_RNE_EN
  localparam logic RNE = 1'b1;
`else
  localparam logic RNE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        n_rst, start, sub, busy, done, overflow;
  logic [31:0] op1, op2, result;
  logic        h_start, h_sub, h_busy, h_done, h_overflow;
  logic [15:0] h_op1, h_op2, h_result;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  fp_addsub_pipe dut (
    .clk(clk), .n_rst(n_rst), .start(start), .sub(sub), .op1(op1), .op2(op2),
    .busy(busy), .result(result), .done(done), .overflow(overflow)
  );

  fp_addsub_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .n_rst(n_rst), .start(h_start), .sub(h_sub), .op1(h_op1), .op2(h_op2),
    .busy(h_busy), .result(h_result), .done(h_done), .overflow(h_overflow)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] r;
    logic        ov;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Exact sum of the two operands as wide integers, then rounded/truncated to single precision.
  function automatic logic [32:0] ref_sp(input logic [31:0] x, input logic [31:0] y, input logic s);
    int ea, eb, emin, p, e, k;
    logic sa, sb, sg;
    logic [127:0] va, vb, mag, rem, half;
    logic [24:0] man;
    ea = int'(x[30:23]);
    eb = int'(y[30:23]);
    sa = x[31];
    sb = y[31] ^ s;
    if (ea == 0 && eb == 0) return {1'b0, sa & sb, 31'd0};
    if (ea == 0) emin = eb;
    else if (eb == 0) emin = ea;
    else emin = (ea < eb) ? ea : eb;
    va = (ea == 0) ? 128'd0 : (128'({1'b1, x[22:0]}) << (ea - emin));
    vb = (eb == 0) ? 128'd0 : (128'({1'b1, y[22:0]}) << (eb - emin));
    if (sa == sb) begin mag = va + vb; sg = sa; end
    else if (va >= vb) begin mag = va - vb; sg = sa; end
    else begin mag = vb - va; sg = sb; end
    if (mag == 128'd0) return 33'd0;
    p = 0;
    for (int i = 0; i < 128; i++) if (mag[i]) p = i;
    e = emin + p - 23;
    if (p > 23) begin
      k    = p - 23;
      man  = 25'(mag >> k);
      rem  = mag & ((128'd1 << k) - 128'd1);
      half = 128'd1 << (k - 1);
      if (RNE && (rem > half || (rem == half && man[0]))) man = man + 25'd1;
    end else begin
      man = 25'(mag << (23 - p));
    end
    if (man[24]) begin man = man >> 1; e = e + 1; end
    if (e >= 255) return {1'b1, sg, 8'hFF, 23'd0};
    if (e < 1) return {1'b0, sg, 31'd0};
    return {1'b0, sg, 8'(e), man[22:0]};
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output logic [31:0] r, output logic ov, output int lat,
                        output logic busy_ok, output logic done_gone);
    @(negedge clk);
    op1 = a; op2 = b; sub = s; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; op1 = $urandom; op2 = $urandom; sub = 1'($urandom);
    lat = 1;
    busy_ok = 1'b1;
    while (!done && lat < 10) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    if (busy) busy_ok = 1'b0;
    r  = result;
    ov = overflow;
    @(posedge clk);
    #1;
    done_gone = !done;
  endtask

  task automatic run_half(input logic [15:0] a, input logic [15:0] b, input logic s,
                          output logic [15:0] r, output int lat);
    @(negedge clk);
    h_op1 = a; h_op2 = b; h_sub = s; h_start = 1'b1;
    @(posedge clk);
    #1;
    h_start = 1'b0;
    lat = 1;
    while (!h_done && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    r = h_result;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [31:0] r, a, b, got;
    logic [15:0] hr;
    logic        ov, s, bok, dg;
    int          lat, ea, eb, d, ndone;

    n_rst = 1'b0; start = 1'b0; sub = 1'b0; op1 = '0; op2 = '0;
    h_start = 1'b0; h_sub = 1'b0; h_op1 = '0; h_op2 = '0;
    #12;
    check("reset_state", 64'({busy, done, overflow, result}), 64'd0);
    @(negedge clk);
    n_rst = 1'b1;

    vecs[0]  = '{32'h40200000, 32'h40600000, 1'b0, 32'h40C00000, 1'b0};
    vecs[1]  = '{32'hC61C4238, 32'h461C4238, 1'b0, 32'h00000000, 1'b0};
    vecs[2]  = '{32'h40840000, 32'h40800000, 1'b1, 32'h3E000000, 1'b0};
    vecs[3]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1};
    vecs[4]  = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0};
    vecs[5]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1'b0};
    vecs[6]  = '{32'h80000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0};
    vecs[7]  = '{32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 1'b0};
    vecs[8]  = '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 1'b0};
    vecs[9]  = '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 1'b0};
    vecs[10] = '{32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 1'b0};
    vecs[11] = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0};
    vecs[12] = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 1'b0};
    vecs[13] = '{32'h3F800001, 32'h33800000, 1'b0, RNE ? 32'h3F800002 : 32'h3F800001, 1'b0};
    vecs[14] = '{32'h7F7FFFFF, 32'h73000000, 1'b0, RNE ? 32'h7F800000 : 32'h7F7FFFFF, RNE};

    for (int i = 0; i < 15; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, r, ov, lat, bok, dg);
      check($sformatf("vec%0d_result", i), 64'({ov, r}), 64'({vecs[i].ov, vecs[i].r}));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
      check($sformatf("vec%0d_busy", i), 64'(bok), 64'd1);
      check($sformatf("vec%0d_done_pulse", i), 64'(dg), 64'd1);
    end

    for (int i = 0; i < 150; i++) begin
      ea = int'($urandom_range(1, 254));
      if ($urandom_range(0, 15) == 0) ea = int'($urandom_range(245, 254));
      d  = int'($urandom_range(0, 40));
      eb = (ea > d) ? ea - d : 0;
      a  = {1'($urandom), 8'(ea), 23'($urandom)};
      b  = {1'($urandom), 8'(eb), 23'($urandom)};
      if ($urandom_range(0, 7) == 0) b = {~a[31], a[30:0]};
      if ($urandom_range(0, 15) == 0) b[30:23] = 8'h00;
      if ($urandom_range(0, 1) == 1) begin r = a; a = b; b = r; end
      s = 1'($urandom);
      run_op(a, b, s, r, ov, lat, bok, dg);
      check($sformatf("rand%0d %h %h sub=%0d", i, a, b, s), 64'({ov, r}), 64'(ref_sp(a, b, s)));
    end

    // start held high with fresh operands while busy and through DONE
    @(negedge clk);
    op1 = 32'h3F800000; op2 = 32'h3F800000; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    ndone = 0;
    got = '0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      if (done) begin ndone++; got = result; end
      if (i >= 4) start = 1'b0;
      else begin op1 = $urandom; op2 = $urandom; sub = 1'($urandom); end
    end
    check("start_while_busy_done_count", 64'(ndone), 64'd1);
    check("start_while_busy_result", 64'(got), 64'h40000000);
    check("start_while_busy_idle", 64'(busy), 64'd0);

    // reset pulse while the operation is in ADD
    run_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, r, ov, lat, bok, dg);
    @(negedge clk);
    op1 = 32'h3F800000; op2 = 32'h3F800000; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #2 n_rst = 1'b0;
    #1;
    check("abort_outputs", 64'({busy, done, overflow, result}), 64'd0);
    @(negedge clk);
    n_rst = 1'b1;
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check("abort_no_done", 64'(ndone), 64'd0);
    check("abort_idle", 64'({busy, result}), 64'd0);

    run_half(16'h3C00, 16'h4000, 1'b0, hr, lat);
    check("half_1p2", 64'({lat[7:0], hr}), 64'({8'd4, 16'h4200}));
    run_half(16'h3C00, 16'h1001, 1'b0, hr, lat);
    check("half_round", 64'(hr), RNE ? 64'h3C01 : 64'h3C00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
